// File: rtl/teclado_varredura_if.sv
// Keypad bus: column drive out to the matrix, row sense back in, and the
// debounced key coordinates and press level for the digit accumulator.
interface teclado_varredura_if;
   logic [3:0] row_in;
   logic [3:0] col_drv;
   logic [3:0] lin;
   logic [3:0] col;
   logic       bot_press;

   modport master (
      output row_in,
      input  col_drv,
      input  lin,
      input  col,
      input  bot_press
   );

   modport slave (
      input  row_in,
      output col_drv,
      output lin,
      output col,
      output bot_press
   );
endinterface

// File: rtl/teclado_varredura.sv
// 4x4 keypad scanner: walks the columns one-hot, debounces press and release,
// and presents lin/col one cycle before the clean bot_press rising edge.
module teclado_varredura #(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic                clk,
   input  logic                rst,
   teclado_varredura_if.slave  bus
);

   localparam int DW = $clog2(SCAN_DIV) + 1;
   localparam int BW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      SCAN,
      DEBOUNCE,
      LOAD,
      PRESSED,
      RELEASE
   } state_t;

   state_t        state_reg;
   logic [DW-1:0] dwell_cnt_reg;
   logic [BW-1:0] deb_cnt_reg;
   logic [3:0]    cand_row_reg;
   logic [3:0]    col_drv_reg;
   logic [3:0]    lin_reg;
   logic [3:0]    col_reg;
   logic          bot_press_reg;

   logic [3:0]    single_bit;
   logic          row_onehot;
   logic          row_match;
   logic          row_zero;
   logic [DW-1:0] dwell_inc;
   logic [BW-1:0] deb_inc;
   logic [3:0]    col_drv_next;

   // Multi-key and ghost patterns never qualify as a candidate.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
         assign single_bit[gi] = (bus.row_in == (4'b0001 << gi));
      end
   endgenerate

   assign row_onehot   = |single_bit;
   assign row_match    = (bus.row_in == cand_row_reg);
   assign row_zero     = (bus.row_in == 4'b0000);
   assign dwell_inc    = (&dwell_cnt_reg) ? dwell_cnt_reg : dwell_cnt_reg + 1'b1;
   assign deb_inc      = (&deb_cnt_reg) ? deb_cnt_reg : deb_cnt_reg + 1'b1;
   assign col_drv_next = {col_drv_reg[0], col_drv_reg[3:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= SCAN;
         dwell_cnt_reg <= '0;
         deb_cnt_reg   <= '0;
         cand_row_reg  <= 4'b0000;
         col_drv_reg   <= 4'b1000;
         lin_reg       <= 4'b0000;
         col_reg       <= 4'b0000;
         bot_press_reg <= 1'b0;
      end else begin
         case (state_reg)
            SCAN: begin
               if (dwell_cnt_reg == DWELL_LAST) begin
                  dwell_cnt_reg <= '0;
                  if (row_onehot) begin
                     cand_row_reg <= bus.row_in;
                     deb_cnt_reg  <= '0;
                     state_reg    <= DEBOUNCE;
                  end else begin
                     col_drv_reg <= col_drv_next;
                  end
               end else begin
                  dwell_cnt_reg <= dwell_inc;
               end
            end

            DEBOUNCE: begin
               if (row_match) begin
                  // lin/col load here so they lead bot_press by a full cycle.
                  if (deb_cnt_reg == DEB_LAST) begin
                     lin_reg     <= cand_row_reg;
                     col_reg     <= col_drv_reg;
                     deb_cnt_reg <= '0;
                     state_reg   <= LOAD;
                  end else begin
                     deb_cnt_reg <= deb_inc;
                  end
               end else begin
                  deb_cnt_reg   <= '0;
                  dwell_cnt_reg <= '0;
                  col_drv_reg   <= col_drv_next;
                  state_reg     <= SCAN;
               end
            end

            LOAD: begin
               bot_press_reg <= 1'b1;
               state_reg     <= PRESSED;
            end

            PRESSED: begin
               if (!row_match) begin
                  deb_cnt_reg <= '0;
                  state_reg   <= RELEASE;
               end
            end

            RELEASE: begin
               if (row_zero) begin
                  if (deb_cnt_reg == DEB_LAST) begin
                     bot_press_reg <= 1'b0;
                     col_drv_reg   <= col_drv_next;
                     dwell_cnt_reg <= '0;
                     deb_cnt_reg   <= '0;
                     state_reg     <= SCAN;
                  end else begin
                     deb_cnt_reg <= deb_inc;
                  end
               end else if (row_match) begin
                  // Contact bounce: the key is still considered held.
                  deb_cnt_reg <= '0;
                  state_reg   <= PRESSED;
               end else begin
                  deb_cnt_reg <= '0;
               end
            end

            default: begin
               state_reg <= SCAN;
            end
         endcase
      end
   end

   assign bus.col_drv   = col_drv_reg;
   assign bus.lin       = lin_reg;
   assign bus.col       = col_reg;
   assign bus.bot_press = bot_press_reg;

endmodule
